// File: rtl/osd_pkg.sv
// Shared state encoding, command constants and small helpers for the OSD
// command arbiter and its SPI byte serializer.
package osd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LOAD  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } osd_state_e;

  localparam logic [7:0] OSD_CMD_WRITE  = 8'h20;
  localparam logic [7:0] OSD_CMD_ENABLE = 8'h40;
  localparam logic [8:0] OSD_MAX_LEN    = 9'd256;

  // SS3 is held low for every state that belongs to a live transaction.
  function automatic logic osd_ss_active(input osd_state_e st);
    return (st == ST_SETUP) || (st == ST_SHIFT) || (st == ST_LOAD) || (st == ST_HOLD);
  endfunction

  function automatic logic [1:0] osd_port_mask(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/osd_spi_shifter.sv
// MSB-first byte serializer: each bit is CLK_DIV cycles with SCK low followed
// by CLK_DIV cycles with SCK high; DI only moves at the start of a low phase.
module osd_spi_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  input  logic       i_go,
  output logic       o_sck,
  output logic       o_di,
  output logic       o_byte_done
);

  logic [7:0] r_cnt;
  logic [7:0] r_sreg;
  logic [2:0] r_bit;
  logic       r_phase;
  logic       r_active;
  logic       r_sck;
  logic       r_di;
  logic       w_last;

  assign w_last      = (r_cnt == 8'(CLK_DIV - 1));
  assign o_byte_done = r_active & r_phase & w_last & (r_bit == 3'd7);
  assign o_sck       = r_sck;
  assign o_di        = r_di;

  // Loading presents bit 7 on DI straight away so it is settled before SCK moves.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cnt    <= 8'd0;
      r_sreg   <= 8'd0;
      r_bit    <= 3'd0;
      r_phase  <= 1'b0;
      r_active <= 1'b0;
      r_sck    <= 1'b0;
      r_di     <= 1'b0;
    end else begin
      if (i_load) begin
        r_sreg <= i_byte;
        r_di   <= i_byte[7];
      end
      if (i_go) begin
        r_active <= 1'b1;
        r_phase  <= 1'b0;
        r_cnt    <= 8'd0;
        r_bit    <= 3'd0;
        r_sck    <= 1'b0;
      end else if (r_active) begin
        if (w_last) begin
          r_cnt <= 8'd0;
          if (!r_phase) begin
            r_phase <= 1'b1;
            r_sck   <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            r_sck   <= 1'b0;
            if (r_bit == 3'd7) begin
              r_active <= 1'b0;
            end else begin
              r_bit  <= r_bit + 3'd1;
              r_sreg <= {r_sreg[6:0], 1'b0};
              r_di   <= r_sreg[6];
            end
          end
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/osd_cmd_arbiter.sv
// Two-port arbiter that frames a command byte plus payload onto the OSD SPI link.
// Define OSD_ARB_RR_EN for round-robin tie breaking; otherwise port 0 wins ties.
module osd_cmd_arbiter
  import osd_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP     = 8
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic [7:0] cmd0_i,
  input  logic [7:0] cmd1_i,
  input  logic [8:0] len0_i,
  input  logic [8:0] len1_i,
  output logic [1:0] rd_o,
  input  logic [7:0] data0_i,
  input  logic [7:0] data1_i,
  output logic [1:0] done_o,
  output logic       busy_o,
  output logic       SPI_SCK,
  output logic       SPI_SS3,
  output logic       SPI_DI
);

  osd_state_e r_state;
  osd_state_e w_nxt;
  logic [15:0] r_cnt;
  logic [8:0]  r_rem;
  logic        r_gnt;
  logic        r_ss3;
  logic        r_busy;
  logic [1:0]  r_rd;
  logic [1:0]  r_done;
  logic        w_pick;
  logic        w_grant;
  logic        w_load;
  logic        w_go;
  logic [7:0]  w_load_byte;
  logic        w_byte_done;

`ifdef OSD_ARB_RR_EN
  logic r_ptr;

  // On a tie the pointer names the port that did not win last time.
  always_comb begin
    if (req_i == 2'b11) begin
      w_pick = r_ptr;
    end else begin
      w_pick = req_i[1];
    end
  end
`else
  assign w_pick = ~req_i[0];
`endif

  osd_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .i_load     (w_load),
    .i_byte     (w_load_byte),
    .i_go       (w_go),
    .o_sck      (SPI_SCK),
    .o_di       (SPI_DI),
    .o_byte_done(w_byte_done)
  );

  // Next-state and shifter control.
  always_comb begin
    w_nxt       = r_state;
    w_grant     = 1'b0;
    w_load      = 1'b0;
    w_go        = 1'b0;
    w_load_byte = 8'd0;
    case (r_state)
      ST_IDLE: begin
        if (req_i != 2'b00) begin
          w_nxt       = ST_SETUP;
          w_grant     = 1'b1;
          w_load      = 1'b1;
          w_load_byte = w_pick ? cmd1_i : cmd0_i;
        end else begin
          w_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (r_cnt == 16'(CLK_DIV - 1)) begin
          w_nxt = ST_SHIFT;
          w_go  = 1'b1;
        end else begin
          w_nxt = ST_SETUP;
        end
      end
      ST_SHIFT: begin
        if (w_byte_done) begin
          w_nxt = (r_rem != 9'd0) ? ST_LOAD : ST_HOLD;
        end else begin
          w_nxt = ST_SHIFT;
        end
      end
      ST_LOAD: begin
        // Second LOAD cycle: the byte fetched by rd_o is now on the data bus.
        if (r_cnt == 16'd1) begin
          w_nxt       = ST_SHIFT;
          w_load      = 1'b1;
          w_go        = 1'b1;
          w_load_byte = r_gnt ? data1_i : data0_i;
        end else begin
          w_nxt = ST_LOAD;
        end
      end
      ST_HOLD: begin
        if (r_cnt == 16'(CLK_DIV - 1)) begin
          w_nxt = ST_GAP;
        end else begin
          w_nxt = ST_HOLD;
        end
      end
      ST_GAP: begin
        if (r_cnt == 16'(GAP - 1)) begin
          w_nxt = ST_IDLE;
        end else begin
          w_nxt = ST_GAP;
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'd0;
      r_rem   <= 9'd0;
      r_gnt   <= 1'b0;
      r_ss3   <= 1'b1;
      r_busy  <= 1'b0;
      r_rd    <= 2'b00;
      r_done  <= 2'b00;
`ifdef OSD_ARB_RR_EN
      r_ptr   <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (w_nxt != r_state) ? 16'd0 : r_cnt + 16'd1;
      if (w_grant) begin
        r_gnt <= w_pick;
        r_rem <= w_pick ? len1_i : len0_i;
      end else if ((r_state == ST_SHIFT) && (w_nxt == ST_LOAD)) begin
        r_rem <= r_rem - 9'd1;
      end
      r_ss3  <= ~osd_ss_active(w_nxt);
      r_busy <= (w_nxt != ST_IDLE);
      r_rd   <= ((r_state == ST_SHIFT) && (w_nxt == ST_LOAD)) ? osd_port_mask(r_gnt) : 2'b00;
      r_done <= ((r_state == ST_HOLD) && (w_nxt == ST_GAP)) ? osd_port_mask(r_gnt) : 2'b00;
`ifdef OSD_ARB_RR_EN
      if (w_grant) begin
        r_ptr <= ~w_pick;
      end
`endif
    end
  end

  assign SPI_SS3 = r_ss3;
  assign busy_o  = r_busy;
  assign rd_o    = r_rd;
  assign done_o  = r_done;

endmodule

// File: tb/tb_osd_cmd_arbiter.sv
// Directed bench for osd_cmd_arbiter (CLK_DIV=2, GAP=8): a transaction table
// plus hand sequences for request drop and mid-transaction reset.
module tb_osd_cmd_arbiter;

  localparam int TB_DIV = 2;
  localparam int TB_GAP = 8;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [1:0] req_i;
  logic [7:0] cmd0_i, cmd1_i;
  logic [8:0] len0_i, len1_i;
  logic [1:0] rd_o;
  logic [7:0] data0_i, data1_i;
  logic [1:0] done_o;
  logic       busy_o;
  logic       SPI_SCK, SPI_SS3, SPI_DI;

  osd_cmd_arbiter #(.CLK_DIV(TB_DIV), .GAP(TB_GAP)) dut (
    .clk_sys(clk_sys), .reset(reset), .req_i(req_i),
    .cmd0_i(cmd0_i), .cmd1_i(cmd1_i), .len0_i(len0_i), .len1_i(len1_i),
    .rd_o(rd_o), .data0_i(data0_i), .data1_i(data1_i),
    .done_o(done_o), .busy_o(busy_o),
    .SPI_SCK(SPI_SCK), .SPI_SS3(SPI_SS3), .SPI_DI(SPI_DI)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec  = 0;
  int n_miss = 0;

  // Link monitor / payload source state (written only by the monitor process).
  bit         m_en = 1'b0;
  int         m_low, m_nbits, m_rd0, m_rd1, m_done0, m_done1;
  int         m_gap = 1000;
  int         m_proto = 0;
  logic       m_prev_ss3 = 1'b1;
  logic       m_prev_sck = 1'b0;
  logic       m_prev_di  = 1'b0;
  logic [7:0] m_bytes [0:299];

  function automatic logic [7:0] pat(input logic port, input int idx);
    return port ? 8'(idx) : 8'(8'hC0 + 8'(idx));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    m_low = 0; m_nbits = 0; m_rd0 = 0; m_rd1 = 0; m_done0 = 0; m_done1 = 0;
    forever begin
      @(negedge clk_sys);
      if (m_en) begin
        if (!SPI_SS3 && m_prev_ss3) begin
          if (m_gap < TB_GAP) begin
            m_proto++;
            $display("FAIL ss3_gap: got %0d cycles expected >= %0d", m_gap, TB_GAP);
          end
          m_low = 0; m_nbits = 0; m_rd0 = 0; m_rd1 = 0; m_done0 = 0; m_done1 = 0;
        end
        if (SPI_SS3) m_gap++; else m_gap = 0;
        if (!SPI_SS3) m_low++;
        if (SPI_SS3 && SPI_SCK) begin
          m_proto++;
          $display("FAIL sck_idle: SCK high while SS3 high");
        end
        if (m_prev_sck && SPI_SCK && (SPI_DI !== m_prev_di)) begin
          m_proto++;
          $display("FAIL di_stable: DI moved while SCK high");
        end
        if (!SPI_SS3 && SPI_SCK && !m_prev_sck && m_nbits < 2400) begin
          m_bytes[m_nbits / 8] = {m_bytes[m_nbits / 8][6:0], SPI_DI};
          m_nbits++;
        end
        if (rd_o[0]) begin data0_i = pat(1'b0, m_rd0); m_rd0++; end
        if (rd_o[1]) begin data1_i = pat(1'b1, m_rd1); m_rd1++; end
        if (done_o[0]) m_done0++;
        if (done_o[1]) m_done1++;
        m_prev_ss3 = SPI_SS3;
        m_prev_sck = SPI_SCK;
        m_prev_di  = SPI_DI;
      end
    end
  end

  task automatic txn(input string nm, input logic [1:0] req, input logic [7:0] c0, input logic [7:0] c1,
                     input logic [8:0] l0, input logic [8:0] l1, input logic ep, input int exp_low,
                     input int drop_at);
    bit         got;
    logic [1:0] dmask;
    logic       ss3_at_done;
    int         k, bad, el;
    logic [7:0] ecmd, elast;
    cmd0_i = c0; cmd1_i = c1; len0_i = l0; len1_i = l1; req_i = req;
    el    = ep ? int'(l1) : int'(l0);
    ecmd  = ep ? c1 : c0;
    got   = 1'b0;
    dmask = 2'b00;
    ss3_at_done = 1'b0;
    for (int t = 0; t < 20000 && !got; t++) begin
      @(negedge clk_sys);
      if (drop_at >= 0 && (ep ? m_rd1 : m_rd0) == drop_at) req_i = req_i & (ep ? 2'b01 : 2'b10);
      if (done_o != 2'b00) begin
        got = 1'b1;
        dmask = done_o;
        ss3_at_done = SPI_SS3;
      end
    end
    req_i = 2'b00;
    chk({nm, "_done_seen"}, {31'd0, got}, 32'd1);
    if (!got) return;
    chk({nm, "_ss3_at_done"}, {31'd0, ss3_at_done}, 32'd1);
    k = 0;
    while (busy_o && k < 100) begin
      @(negedge clk_sys);
      k++;
    end
    chk({nm, "_busy_fall"}, 32'(k), 32'(TB_GAP));
    chk({nm, "_done_port"}, {30'd0, dmask}, ep ? 32'd2 : 32'd1);
    chk({nm, "_done_count"}, 32'(m_done0 + m_done1), 32'd1);
    chk({nm, "_ss3_low"}, 32'(m_low), 32'(exp_low));
    chk({nm, "_rd_grant"}, 32'(ep ? m_rd1 : m_rd0), 32'(el));
    chk({nm, "_rd_other"}, 32'(ep ? m_rd0 : m_rd1), 32'd0);
    chk({nm, "_bits"}, 32'(m_nbits), 32'((el + 1) * 8));
    chk({nm, "_cmd"}, {24'd0, m_bytes[0]}, {24'd0, ecmd});
    bad = 0;
    for (int i = 1; i <= el; i++) if (m_bytes[i] !== pat(ep, i - 1)) bad++;
    chk({nm, "_payload_errs"}, 32'(bad), 32'd0);
    elast = (el == 0) ? ecmd : pat(ep, el - 1);
    chk({nm, "_last_byte"}, {24'd0, m_bytes[el]}, {24'd0, elast});
  endtask

  typedef struct {
    logic [1:0] req;
    logic [7:0] c0, c1;
    logic [8:0] l0, l1;
    logic       ep;
    int         low;
  } vec_t;

  vec_t vt [0:7];

  initial begin
    bit reached;
    // Ties first so the round-robin pointer starts from its reset value.
`ifdef OSD_ARB_RR_EN
    vt[0] = '{2'b11, 8'h22, 8'h25, 9'd1, 9'd2, 1'b0, 70};
    vt[1] = '{2'b11, 8'h22, 8'h25, 9'd1, 9'd2, 1'b1, 104};
    vt[2] = '{2'b11, 8'h22, 8'h25, 9'd1, 9'd2, 1'b0, 70};
    vt[3] = '{2'b11, 8'h22, 8'h25, 9'd1, 9'd2, 1'b1, 104};
`else
    vt[0] = '{2'b11, 8'h22, 8'h25, 9'd1, 9'd2, 1'b0, 70};
    vt[1] = '{2'b11, 8'h22, 8'h25, 9'd1, 9'd2, 1'b0, 70};
    vt[2] = '{2'b11, 8'h22, 8'h25, 9'd1, 9'd2, 1'b0, 70};
    vt[3] = '{2'b11, 8'h22, 8'h25, 9'd1, 9'd2, 1'b0, 70};
`endif
    vt[4] = '{2'b01, 8'h41, 8'h00, 9'd0, 9'd0,   1'b0, 36};
    vt[5] = '{2'b10, 8'h00, 8'h23, 9'd0, 9'd256, 1'b1, 8740};
    vt[6] = '{2'b10, 8'h00, 8'h40, 9'd0, 9'd0,   1'b1, 36};
    vt[7] = '{2'b01, 8'h21, 8'h00, 9'd3, 9'd0,   1'b0, 138};

    reset = 1'b1; req_i = 2'b00; cmd0_i = 8'h00; cmd1_i = 8'h00;
    len0_i = 9'd0; len1_i = 9'd0; data0_i = 8'h00; data1_i = 8'h00;
    repeat (3) @(negedge clk_sys);
    chk("rst_ss3", {31'd0, SPI_SS3}, 32'd1);
    chk("rst_sck", {31'd0, SPI_SCK}, 32'd0);
    chk("rst_di", {31'd0, SPI_DI}, 32'd0);
    chk("rst_rd", {30'd0, rd_o}, 32'd0);
    chk("rst_done", {30'd0, done_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("idle_busy", {31'd0, busy_o}, 32'd0);
    m_en = 1'b1;
    @(negedge clk_sys);

    for (int i = 0; i < 8; i++)
      txn($sformatf("v%0d", i), vt[i].req, vt[i].c0, vt[i].c1, vt[i].l0, vt[i].l1, vt[i].ep, vt[i].low, -1);

    // Port 0 withdraws its request while payload byte 2 is going out.
    txn("drop", 2'b01, 8'h20, 8'h00, 9'd4, 9'd0, 1'b0, 172, 2);

    // Reset after 13 bits of a write.
    cmd0_i = 8'h21; len0_i = 9'd2; req_i = 2'b01;
    reached = 1'b0;
    for (int t = 0; t < 2000 && !reached; t++) begin
      @(negedge clk_sys);
      if (m_nbits >= 13) reached = 1'b1;
    end
    chk("rst_mid_reached", {31'd0, reached}, 32'd1);
    reset = 1'b1;
    @(negedge clk_sys);
    chk("rst_mid_ss3", {31'd0, SPI_SS3}, 32'd1);
    chk("rst_mid_sck", {31'd0, SPI_SCK}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    reset = 1'b0; req_i = 2'b00;
    repeat (TB_GAP + 2) @(negedge clk_sys);
    chk("rst_mid_no_done", 32'(m_done0 + m_done1), 32'd0);
    chk("rst_mid_partial", {31'd0, (m_nbits < 24) ? 1'b1 : 1'b0}, 32'd1);
    txn("post_rst_tie", 2'b11, 8'h42, 8'h43, 9'd0, 9'd0, 1'b0, 36, -1);

    chk("protocol_errors", 32'(m_proto), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
